poly1305_mctx_core: RTL and testbench
=====================================

POLY1305_MCTX_CORE -- requirements
Module: poly1305_mctx_core

Interface
REQ-001 SHALL have parameter NUM_CTX, default 4, number of independent MAC contexts (1..16).
REQ-002 SHALL have parameter CTX_W, default 2, context index width, equal to max(1, clog2(NUM_CTX)).
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  command: 0 INIT, 1 BLOCK, 2 FINISH, 3 reserved
- cmd_ctx  in  CTX_W  target context
- key  in  256  INIT key; byte 0 at [255:248]
- block  in  128  BLOCK data; byte 0 at [127:120]
- blocklen  in  5  valid bytes in block, 0..16
- tag_valid  out  1  tag available
- tag_ready  in  1  tag consumed when high with tag_valid
- tag  out  128  Poly1305 tag; byte 0 at [127:120]
- tag_ctx  out  CTX_W  context that produced tag
- err  out  1  one-cycle error pulse
- err_code  out  2  1 bad op, 2 context not initialised, 3 blocklen>16
- ctx_init  out  NUM_CTX  per-context initialised flags

Function
REQ-004 SHALL hold per context: h (130-bit accumulator as 5x32 words), clamped r (4x32), s (4x32) and an initialised flag.
REQ-005 SHALL use one shared poly1305_pblock and one shared poly1305_final instance, time-multiplexed across contexts.
REQ-006 SHALL implement states IDLE, LOAD, PB_START, PB_WAIT, FIN_START, FIN_WAIT, TAG_OUT; cmd_ready SHALL be high only in IDLE.
REQ-007 SHALL accept a command, and latch op, ctx, block and blocklen, on any cycle where cmd_valid and cmd_ready are both high.
REQ-008 INIT SHALL set r = little-endian key words 0..3 masked 0x0fffffff, 0x0ffffffc, 0x0ffffffc, 0x0ffffffc; set s = little-endian key words 4..7; clear h; set the flag; return to IDLE the next cycle.
REQ-009 INIT on an already initialised context SHALL re-key it and discard its accumulator.
REQ-010 BLOCK with blocklen 16 SHALL form c = le(block) + 2^128; with blocklen 1..15 SHALL form c = le(first blocklen bytes) + 2^(8*blocklen).
REQ-011 BLOCK SHALL proceed LOAD -> PB_START (one-cycle start pulse) -> PB_WAIT -> write h_new to the context when pblock ready -> IDLE.
REQ-012 BLOCK with blocklen 0 SHALL be accepted as a no-op, context unchanged, return to IDLE in 1 cycle.
REQ-013 FINISH SHALL proceed FIN_START -> FIN_WAIT -> TAG_OUT; tag = byte-reversed (h + s) mod 2^128.
REQ-014 In TAG_OUT, tag_valid, tag and tag_ctx SHALL stay stable until tag_ready; on handshake the FSM SHALL clear the context flag and h, and go to IDLE.
REQ-015 Commands to other contexts SHALL NOT alter a context's state; interleaved per-block commands across contexts SHALL yield the same tags as serial processing.
REQ-016 cmd_op 3 SHALL be accepted, pulse err with code 1, and change no state.
REQ-017 BLOCK or FINISH to an uninitialised context SHALL be accepted, pulse err with code 2, and change no state.
REQ-018 blocklen greater than 16 on BLOCK SHALL be accepted, pulse err with code 3, and change no state.
REQ-019 err SHALL pulse one cycle after acceptance; FSM SHALL return to IDLE the same cycle.
REQ-020 cmd_ctx >= NUM_CTX SHALL be treated as error code 1.

Reset
REQ-021 When reset_n is low at a clock edge, the block SHALL enter IDLE and clear all h, r, s and flags.
REQ-022 During reset, outputs SHALL be: cmd_ready 1 (after release), tag_valid 0, tag 0, tag_ctx 0, err 0, err_code 0, ctx_init 0.
REQ-023 Reset mid-operation (any state) SHALL abort the operation with no tag emitted; all contexts SHALL be uninitialised.

Verification
REQ-024 Test INIT ctx0 with key 85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b, then BLOCKs of "Cryptographic Forum Research Group" (16, 16, 2 bytes), then FINISH -> expect tag a8061dc1305136c6c22b8baf0c0127a9 with tag_ctx 0.
REQ-025 Test REQ-024 on ctx1 and ctx3 with blocks interleaved, and ctx3 holding a zero key -> expect ctx1 tag a8061dc1...27a9 and ctx3 tag 0.
REQ-026 Test FINISH on uninitialised ctx2 -> expect err 1 cycle with err_code 2, no tag_valid, ctx_init unchanged.
REQ-027 Test holding tag_ready low for 10 cycles -> expect tag stable, cmd_ready 0 throughout, ctx_init bit cleared only after handshake.
REQ-028 Test asserting reset_n low during PB_WAIT -> expect ctx_init 0, tag_valid 0, and cmd_ready 1 one cycle after release.
REQ-029 Test blocklen 0 and blocklen 17 -> expect no-op (no err) and err code 3 respectively; final tag unaffected.

Source files
------------

// File: rtl/poly1305_mctx_core.sv
// poly1305_mctx_core: multi-context Poly1305 MAC sharing one block engine and one finaliser
module poly1305_pblock (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [129:0] i_h,
  input  logic [127:0] i_r,
  input  logic [128:0] i_c,
  output logic         o_ready,
  output logic [129:0] o_h
);
  localparam logic [130:0] P = {1'b0, 2'b11, {31{4'hf}}, 4'hb};
  logic [130:0] w_a;
  logic [258:0] w_prod;
  logic [132:0] w_t1;
  logic [130:0] w_t2;
  logic         r_ready;
  logic [129:0] r_h;
  // fold twice using 2^130 == 5 (mod p), then one conditional subtract gives h < p
  always_comb begin
    w_a = 131'(i_h) + 131'(i_c);
    w_prod = 259'(w_a) * 259'(i_r);
    w_t1 = 133'(w_prod[129:0]) + 133'(w_prod[258:130]) * 133'd5;
    w_t2 = 131'(w_t1[129:0]) + 131'(w_t1[132:130]) * 131'd5;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_h <= '0;
    end else begin
      r_ready <= i_start;
      if (i_start) r_h <= 130'(w_t2 >= P ? w_t2 - P : w_t2);
    end
  end
  assign o_ready = r_ready;
  assign o_h = r_h;
endmodule

module poly1305_final (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [127:0] i_h,
  input  logic [127:0] i_s,
  output logic         o_ready,
  output logic [127:0] o_tag
);
  logic [127:0] w_sum;
  logic [127:0] w_rev;
  logic         r_ready;
  logic [127:0] r_tag;
  assign w_sum = i_h + i_s;
  for (genvar i = 0; i < 16; i++) begin : g_rev
    assign w_rev[127-8*i -: 8] = w_sum[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_tag <= '0;
    end else begin
      r_ready <= i_start;
      if (i_start) r_tag <= w_rev;
    end
  end
  assign o_ready = r_ready;
  assign o_tag = r_tag;
endmodule

module poly1305_mctx_core #(
  parameter int NUM_CTX = 4,
  parameter int CTX_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CTX_W-1:0]   cmd_ctx,
  input  logic [255:0]       key,
  input  logic [127:0]       block,
  input  logic [4:0]         blocklen,
  output logic               tag_valid,
  input  logic               tag_ready,
  output logic [127:0]       tag,
  output logic [CTX_W-1:0]   tag_ctx,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [NUM_CTX-1:0] ctx_init
);
  localparam int NF = 2 ** CTX_W;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  typedef enum logic [2:0] {IDLE, LOAD, PB_START, PB_WAIT, FIN_START, FIN_WAIT, TAG_OUT} state_t;
  state_t             r_state;
  logic [CTX_W-1:0]   r_ctx;
  logic [127:0]       r_block;
  logic [4:0]         r_len;
  logic [128:0]       r_c;
  logic [129:0]       r_h [NUM_CTX];
  logic [127:0]       r_r [NUM_CTX];
  logic [127:0]       r_s [NUM_CTX];
  logic [NUM_CTX-1:0] r_init;
  logic [127:0]       r_tag;
  logic               r_tag_valid;
  logic [CTX_W-1:0]   r_tag_ctx;
  logic               r_err;
  logic [1:0]         r_err_code;
  logic [255:0]       w_key_le;
  logic [127:0]       w_blk_le;
  logic [7:0]         w_sh;
  logic [128:0]       w_c;
  logic [NF-1:0]      w_flags;
  logic [1:0]         w_code;
  logic               w_pb_ready, w_fin_ready;
  logic [129:0]       w_pb_h;
  logic [127:0]       w_fin_tag;
  for (genvar i = 0; i < 32; i++) begin : g_key
    assign w_key_le[8*i +: 8] = key[255-8*i -: 8];
  end
  for (genvar i = 0; i < 16; i++) begin : g_blk
    assign w_blk_le[8*i +: 8] = r_block[127-8*i -: 8];
  end
  // partial blocks keep only the first blocklen bytes and place the pad bit just above them
  assign w_sh = {r_len, 3'b000};
  assign w_c = ({1'b0, w_blk_le} & ((129'd1 << w_sh) - 129'd1)) | (129'd1 << w_sh);
  assign w_flags = NF'(r_init);
  assign w_code = (cmd_op == 2'd3 || int'(cmd_ctx) >= NUM_CTX) ? 2'd1 :
                  (cmd_op != 2'd0 && !w_flags[cmd_ctx]) ? 2'd2 :
                  (cmd_op == 2'd1 && blocklen > 5'd16) ? 2'd3 : 2'd0;
  poly1305_pblock u_pblock (
    .clk(clk), .reset_n(reset_n), .i_start(r_state == PB_START), .i_h(r_h[r_ctx]),
    .i_r(r_r[r_ctx]), .i_c(r_c), .o_ready(w_pb_ready), .o_h(w_pb_h)
  );
  poly1305_final u_final (
    .clk(clk), .reset_n(reset_n), .i_start(r_state == FIN_START), .i_h(r_h[r_ctx][127:0]),
    .i_s(r_s[r_ctx]), .o_ready(w_fin_ready), .o_tag(w_fin_tag)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ctx <= '0;
      r_block <= '0;
      r_len <= '0;
      r_c <= '0;
      r_init <= '0;
      r_tag <= '0;
      r_tag_valid <= 1'b0;
      r_tag_ctx <= '0;
      r_err <= 1'b0;
      r_err_code <= '0;
      for (int n = 0; n < NUM_CTX; n++) begin
        r_h[n] <= '0;
        r_r[n] <= '0;
        r_s[n] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      r_err_code <= '0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_ctx <= cmd_ctx;
          r_block <= block;
          r_len <= blocklen;
          if (w_code != 2'd0) begin
            r_err <= 1'b1;
            r_err_code <= w_code;
          end else if (cmd_op == 2'd0) begin
            r_r[cmd_ctx] <= w_key_le[127:0] & CLAMP;
            r_s[cmd_ctx] <= w_key_le[255:128];
            r_h[cmd_ctx] <= '0;
            r_init[cmd_ctx] <= 1'b1;
          end else if (cmd_op == 2'd1) r_state <= (blocklen == 5'd0) ? IDLE : LOAD;
          else r_state <= FIN_START;
        end
        LOAD: begin
          r_c <= w_c;
          r_state <= PB_START;
        end
        PB_START: r_state <= PB_WAIT;
        PB_WAIT: if (w_pb_ready) begin
          r_h[r_ctx] <= w_pb_h;
          r_state <= IDLE;
        end
        FIN_START: r_state <= FIN_WAIT;
        FIN_WAIT: if (w_fin_ready) begin
          r_tag <= w_fin_tag;
          r_tag_valid <= 1'b1;
          r_tag_ctx <= r_ctx;
          r_state <= TAG_OUT;
        end
        TAG_OUT: if (tag_ready) begin
          r_tag_valid <= 1'b0;
          r_init[r_ctx] <= 1'b0;
          r_h[r_ctx] <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign cmd_ready = (r_state == IDLE);
  assign tag_valid = r_tag_valid;
  assign tag = r_tag;
  assign tag_ctx = r_tag_ctx;
  assign err = r_err;
  assign err_code = r_err_code;
  assign ctx_init = r_init;
endmodule

// File: tb/tb_poly1305_mctx_core.sv
// tb_poly1305_mctx_core: scoreboard bench with a big-number Poly1305 reference model
module tb_poly1305_mctx_core;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam logic [255:0] RFC_KEY = 256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b;
  localparam logic [127:0] RFC_TAG = 128'ha8061dc1305136c6c22b8baf0c0127a9;
  localparam logic [127:0] B1 = 128'h43727970746f6772617068696320466f;
  localparam logic [127:0] B2 = 128'h72756d2052657365617263682047726f;
  localparam logic [263:0] P = (264'd1 << 130) - 264'd5;

  logic clk = 0, reset_n = 0, cmd_valid = 0, tag_ready = 1;
  logic cmd_ready, tag_valid, err;
  logic [1:0] cmd_op = 0, err_code;
  logic [CW-1:0] cmd_ctx = 0, tag_ctx;
  logic [255:0] key = 0;
  logic [127:0] block = 0, tag;
  logic [4:0] blocklen = 0;
  logic [NC-1:0] ctx_init;

  poly1305_mctx_core #(.NUM_CTX(NC), .CTX_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ctx(cmd_ctx), .key(key), .block(block), .blocklen(blocklen), .tag_valid(tag_valid),
    .tag_ready(tag_ready), .tag(tag), .tag_ctx(tag_ctx), .err(err), .err_code(err_code),
    .ctx_init(ctx_init)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [1:0] err_q[$];
  logic [127:0] tag_q[$];
  logic [CW-1:0] tctx_q[$];
  logic [263:0] m_h[NC], m_r[NC], m_s[NC];
  logic [NC-1:0] m_init = '0;
  bit use_kat = 0;
  logic [127:0] kat = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // little-endian integer from the first n bytes of a byte-0-at-MSB string
  function automatic logic [263:0] le_val(input logic [255:0] msb, input int n);
    logic [263:0] v;
    v = '0;
    for (int j = n - 1; j >= 0; j--) v = v * 264'd256 + 264'(msb[255-8*j -: 8]);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_h[c] = '0; m_r[c] = '0; m_s[c] = '0;
    end
    m_init = '0;
    err_q.delete(); tag_q.delete(); tctx_q.delete();
  endtask

  task automatic model_cmd(input logic [1:0] op, input int ctx, input logic [255:0] k,
                           input logic [127:0] b, input int len);
    logic [263:0] c, t;
    logic [127:0] tg;
    if (op == 3 || ctx >= NC) err_q.push_back(2'd1);
    else if (op != 0 && !m_init[ctx]) err_q.push_back(2'd2);
    else if (op == 1 && len > 16) err_q.push_back(2'd3);
    else if (op == 0) begin
      m_r[ctx] = le_val(k, 16) & 264'h0ffffffc0ffffffc0ffffffc0fffffff;
      m_s[ctx] = le_val(k << 128, 16);
      m_h[ctx] = '0;
      m_init[ctx] = 1'b1;
    end else if (op == 1) begin
      if (len > 0) begin
        c = le_val({b, 128'b0}, len) + (264'd1 << (8 * len));
        m_h[ctx] = ((m_h[ctx] + c) * m_r[ctx]) % P;
      end
    end else begin
      t = (m_h[ctx] + m_s[ctx]) % (264'd1 << 128);
      for (int j = 0; j < 16; j++) tg[127-8*j -: 8] = t[8*j +: 8];
      tag_q.push_back(use_kat ? kat : tg);
      tctx_q.push_back(CW'(ctx));
      use_kat = 0;
      m_init[ctx] = 1'b0;
      m_h[ctx] = '0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", cmd_ready, 1);
    chk("ctx_init", ctx_init, m_init);
  endtask

  task automatic send(input logic [1:0] op, input int ctx, input logic [255:0] k,
                      input logic [127:0] b, input int len, input bit wt);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1; cmd_op = op; cmd_ctx = CW'(ctx); key = k; block = b; blocklen = 5'(len);
    @(posedge clk);
    #1 cmd_valid = 0;
    model_cmd(op, ctx, k, b, len);
    if (wt) wait_idle();
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rfc_msg(input int ctx);
    send(1, ctx, '0, B1, 16, 1);
    send(1, ctx, '0, B2, 16, 1);
    send(1, ctx, '0, {16'h7570, 112'(rnd256())}, 2, 1);
  endtask

  // monitor: err pulses and tag handshakes are popped from the scoreboard queues
  always @(negedge clk) begin
    if (reset_n) begin
      if (err) begin
        if (err_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL err_unexpected: err code %0d with none expected", err_code);
        end else chk("err_code", err_code, err_q.pop_front());
      end
      if (tag_valid && tag_ready) begin
        if (tag_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tag_unexpected: tag %0h ctx %0d with none expected", tag, tag_ctx);
        end else begin
          chk("tag", tag, tag_q.pop_front());
          chk("tag_ctx", tag_ctx, tctx_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tag_valid", tag_valid, 0);
    chk("rst_tag", tag, 0);
    chk("rst_tag_ctx", tag_ctx, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_ctx_init", ctx_init, 0);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    send(0, 0, RFC_KEY, '0, 0, 1);
    rfc_msg(0);
    kat = RFC_TAG; use_kat = 1;
    send(2, 0, '0, '0, 0, 1);

    send(0, 1, RFC_KEY, '0, 0, 1);
    send(0, 3, '0, '0, 0, 1);
    send(1, 1, '0, B1, 16, 1);
    send(1, 3, '0, 128'(rnd256()), 16, 1);
    send(1, 1, '0, B2, 16, 1);
    send(1, 3, '0, 128'(rnd256()), 9, 1);
    send(1, 1, '0, {16'h7570, 112'(rnd256())}, 2, 1);
    kat = '0; use_kat = 1;
    send(2, 3, '0, '0, 0, 1);
    kat = RFC_TAG; use_kat = 1;
    send(2, 1, '0, '0, 0, 1);

    send(2, 2, '0, '0, 0, 1);
    chk("uninit_no_tag", tag_valid, 0);

    send(0, 0, RFC_KEY, '0, 0, 1);
    send(1, 0, '0, 128'(rnd256()), 0, 1);
    send(1, 0, '0, 128'(rnd256()), 17, 1);
    rfc_msg(0);
    kat = RFC_TAG; use_kat = 1;
    send(2, 0, '0, '0, 0, 1);
    send(3, 0, rnd256(), '0, 5, 1);

    send(0, 2, rnd256(), '0, 0, 1);
    send(1, 2, '0, 128'(rnd256()), 16, 1);
    #0 tag_ready = 0;
    send(2, 2, '0, '0, 0, 0);
    k = 0;
    while (!tag_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("stall_tag_valid", tag_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_tag", tag, tag_q.size() > 0 ? tag_q[0] : 128'hx);
      chk("stall_tag_ctx", tag_ctx, 2);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_ctx_init", ctx_init[2], 1);
    end
    @(posedge clk); #1 tag_ready = 1;
    wait_idle();

    send(0, 0, RFC_KEY, '0, 0, 1);
    send(0, 1, rnd256(), '0, 0, 1);
    send(1, 0, '0, B1, 16, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("midrst_ctx_init", ctx_init, 0);
    chk("midrst_tag_valid", tag_valid, 0);
    chk("midrst_err", err, 0);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("midrst_cmd_ready", cmd_ready, 1);
    send(2, 0, '0, '0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      int sel, len;
      logic [1:0] op;
      sel = $urandom_range(0, 9);
      op = sel < 2 ? 2'd0 : sel < 7 ? 2'd1 : sel < 9 ? 2'd2 : 2'd3;
      len = $urandom_range(0, 1) ? 16 : $urandom_range(0, 18);
      send(op, $urandom_range(0, NC - 1), rnd256(), 128'(rnd256()), len, 1);
    end

    repeat (3) @(negedge clk);
    chk("err_q_drained", err_q.size(), 0);
    chk("tag_q_drained", tag_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
